// File: rtl/carrd_pkg.sv
// Shared constants and types for the vector register file writeback sink.
// The v_sel_dest encodings are also used by the writeback stage that drives this block.
package carrd_pkg;

    localparam int NUM_VREGS = 32;
    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 128;
    localparam int VLEN      = NUM_LANES * LANE_W;
    localparam int XLEN      = 32;
    localparam int VADDR_W   = $clog2(NUM_VREGS);

    typedef logic [VADDR_W-1:0] vreg_addr_t;
    typedef logic [VLEN-1:0]    vreg_t;

    typedef enum logic [1:0] {
        VSEL_NONE = 2'd0,
        VSEL_V    = 2'd1,
        VSEL_X    = 2'd2
    } v_sel_dest_t;

    typedef struct packed {
        vreg_addr_t      addr;
        logic [XLEN-1:0] data;
    } xwb_entry_t;

endpackage

// File: rtl/carrd_xwb_fifo.sv
// Small FIFO for scalar writeback results; the head entry is presented on a valid/ready port.
module carrd_xwb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] head,
    output logic         full,
    output logic         overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          pop;
    logic          accept;

    // Handshake: a beat transfers on a rising edge where valid && ready; head is held
    // unchanged while valid && !ready. A push into a full FIFO is accepted only if the
    // head leaves on the same edge, otherwise it is dropped and flagged via overflow.
    assign valid    = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign head     = mem[rd_ptr];
    assign pop      = valid && ready;
    assign accept   = push && (!full || pop);
    assign overflow = push && full && !pop;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/carrd_vrf_wb_sink.sv
// Writeback sink: commits vector writes to the register file, tracks outstanding destinations,
// serves two write-first read ports and forwards scalar results through a small queue.
module carrd_vrf_wb_sink
    import carrd_pkg::*;
#(
    parameter int XQ_DEPTH = 2
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         v_reg_wr_en,
    input  logic         x_reg_wr_en,
    input  logic [4:0]   reg_wr_addr,
    input  logic [127:0] reg_wr_data,
    input  logic [127:0] reg_wr_data_2,
    input  logic [127:0] reg_wr_data_3,
    input  logic [127:0] reg_wr_data_4,
    input  logic         resv_en,
    input  logic [4:0]   resv_addr,
    input  logic [4:0]   rd_addr_a,
    input  logic [4:0]   rd_addr_b,
    output logic [511:0] rd_data_a,
    output logic [511:0] rd_data_b,
    output logic [31:0]  vbusy,
    output logic         x_wb_valid,
    input  logic         x_wb_ready,
    output logic [4:0]   x_wb_addr,
    output logic [31:0]  x_wb_data,
    output logic         x_q_full,
    output logic         wb_err
);

    vreg_t       vregs [NUM_VREGS];
    vreg_t       wr_vec;
    logic [31:0] busy_next;
    v_sel_dest_t wr_sel;
    logic        prev_x_en;
    vreg_addr_t  prev_addr;
    logic        x_push_req;
    logic        x_push;
    logic        dual_err;
    logic        overflow;
    xwb_entry_t  push_entry;
    xwb_entry_t  head_entry;

    assign wr_vec = {reg_wr_data_4, reg_wr_data_3, reg_wr_data_2, reg_wr_data};

    // Vector wins when both enables are raised; the scalar push is then suppressed.
    always_comb begin
        wr_sel = VSEL_NONE;
        if (v_reg_wr_en) begin
            wr_sel = VSEL_V;
        end else if (x_reg_wr_en) begin
            wr_sel = VSEL_X;
        end
    end

    assign dual_err   = v_reg_wr_en && x_reg_wr_en;
    assign x_push_req = x_reg_wr_en && (!prev_x_en || (reg_wr_addr != prev_addr));
    assign x_push     = x_push_req && (wr_sel == VSEL_X);
    assign push_entry = '{addr: reg_wr_addr, data: reg_wr_data[XLEN-1:0]};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_VREGS; i++) begin
                vregs[i] <= '0;
            end
        end else if (wr_sel == VSEL_V) begin
            vregs[reg_wr_addr] <= wr_vec;
        end
    end

    // Write-first: a same-edge commit to the read address is forwarded.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            rd_data_a <= (v_reg_wr_en && (rd_addr_a == reg_wr_addr)) ? wr_vec : vregs[rd_addr_a];
            rd_data_b <= (v_reg_wr_en && (rd_addr_b == reg_wr_addr)) ? wr_vec : vregs[rd_addr_b];
        end
    end

    // Reserve is applied after the commit clear so a new owner keeps the bit set.
    always_comb begin
        busy_next = vbusy;
        if (v_reg_wr_en) begin
            busy_next[reg_wr_addr] = 1'b0;
        end
        if (resv_en) begin
            busy_next[resv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vbusy     <= '0;
            prev_x_en <= 1'b0;
            prev_addr <= '0;
            wb_err    <= 1'b0;
        end else begin
            vbusy     <= busy_next;
            prev_x_en <= x_reg_wr_en;
            prev_addr <= reg_wr_addr;
            if (dual_err || overflow) begin
                wb_err <= 1'b1;
            end
        end
    end

    carrd_xwb_fifo #(
        .DEPTH (XQ_DEPTH),
        .W     ($bits(xwb_entry_t))
    ) u_xwb_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (x_push),
        .push_data (push_entry),
        .valid     (x_wb_valid),
        .ready     (x_wb_ready),
        .head      (head_entry),
        .full      (x_q_full),
        .overflow  (overflow)
    );

    assign x_wb_addr = head_entry.addr;
    assign x_wb_data = head_entry.data;

endmodule
